seg_display_scanner: RTL and testbench
======================================

Name: seg_display_scanner

Overview:
- Time-multiplexed driver for the 4-digit, common-anode seven-segment display on the Nexys3 board.
- Holds a 16-bit value and steps through its four nibbles at a fixed refresh rate.
- Presents one nibble at a time to the downstream hex-to-seven-segment decoder, with the matching active-low anode select and decimal point.
- Sits between the processor's display register (for example PC or ALU result) and the decoder.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); must be >= 2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value_in  in  16  value to display; nibble 0 is the rightmost digit
- load  in  1  single-cycle strobe; captures value_in
- dp_in  in  4  decimal point request per digit, active-high
- lz_blank_en  in  1  enables leading-zero blanking
- hex_out  out  4  nibble for the current digit; feeds the decoder hexIn
- an_out  out  4  anode selects, active-low, at most one low
- dp_out  out  1  decimal point, active-low
- digit_idx  out  2  index of the digit currently driven

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; reset is sampled only on the rising edge of clk.
- Reset values:
  - prescaler = 0
  - digit_idx = 3
  - value register = 16'h0000
  - hex_out = 4'h0
  - an_out = 4'b1111 (all digits off)
  - dp_out = 1
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted for exactly one cycle when the count equals REFRESH_DIV-1.
- Digit stepping: on tick, digit_idx <= digit_idx+1 mod 4 (3 wraps to 0). The first tick after reset therefore selects digit 0.
- Output registers:
  - hex_out, an_out and dp_out are registered and update only on tick, so the display is glitch-free between ticks.
  - They reflect the new digit_idx in the cycle after the tick edge.
- Per-digit outputs for digit i:
  - hex_out = value_reg[4i+3:4i]
  - an_out = ~(4'b0001 << i)
  - dp_out = ~dp_in[i]
  - dp_in is sampled at the tick; it is not latched by load.
- Load:
  - When load is high, value_reg <= value_in on that edge.
  - The new value becomes visible from the next tick onward.
  - Load and tick in the same cycle: the tick uses the old value_reg; the new value applies from the following tick.
  - Back-to-back loads: the last one wins.
- Leading-zero blanking (lz_blank_en = 1):
  - Digit i (i = 1..3) is blanked when value_reg[15:4i] == 0.
  - A blanked digit drives an_out = 4'b1111 and dp_out = 1; hex_out still carries the nibble.
  - Digit 0 is never blanked, so 16'h0000 displays as "0".
  - lz_blank_en is sampled at each tick.
- reset mid-frame returns every register to its reset value on that edge, regardless of load or tick.
- No combinational path from inputs to outputs.
- Refresh timing: each digit is lit for REFRESH_DIV cycles; a full frame takes 4*REFRESH_DIV cycles.

Decomposition:
- Shared display package holds:
  - NUM_DIGITS = 4
  - ANODE_OFF = 4'b1111
  - DP_OFF = 1'b1
  - the default REFRESH_DIV
  - the one-hot active-low anode pattern function
- One sub-module is natural: refresh_prescaler (parameterised modulo-N counter with a one-cycle tick output).
- The existing decoder is instantiated beside this block at top level, not inside it.

Test Plan:
All scenarios use REFRESH_DIV = 4.
1. Reset, then idle: an_out = 1111 and dp_out = 1 for 4 cycles. On the first tick (cycle 3 after reset release), an_out = 1110 and hex_out = 0 on the next cycle.
2. Load 16'hA3C5, run 16 cycles: hex_out sequence 5, C, 3, A with an_out 1110, 1101, 1011, 0111; each digit lasts 4 cycles; then the sequence wraps to digit 0.
3. lz_blank_en = 1, load 16'h0007: digit 0 shows 7 with an_out 1110; digits 1–3 give an_out 1111. Load 16'h0000: only digit 0 is lit, showing 0.
4. dp_in = 4'b0100, value 16'h1234: dp_out = 0 only while an_out = 1011, otherwise 1. Repeat with lz_blank_en = 1 and value 16'h0004: digit 2 is blanked, so dp_out stays 1.
5. Assert load with 16'hFFFF in the same cycle as a tick while 16'h1111 is held: the tick shows 1; the next tick shows F.
6. Assert reset mid-frame while an_out = 1011: the next cycle gives an_out = 1111, hex_out = 0, digit_idx = 3, value cleared; after release, the first tick shows digit 0 = 0.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
package seg_display_pkg;

    localparam int         NUM_DIGITS          = 4;
    localparam int         REFRESH_DIV_DEFAULT = 100000;
    localparam logic [3:0] ANODE_OFF           = 4'b1111;
    localparam logic       DP_OFF              = 1'b1;

    // Active-low one-hot anode select for a digit position.
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_display_scanner_prescaler.sv
// Modulo-N counter producing a one-cycle tick on its terminal count.
module refresh_prescaler #(
    parameter int DIV = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Scans a 16-bit value across four common-anode digits, one nibble per slot,
// with optional leading-zero blanking and per-digit decimal points.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank_en,
    output logic [3:0]  hex_out,
    output logic [3:0]  an_out,
    output logic        dp_out,
    output logic [1:0]  digit_idx
);

    logic        tick;
    logic [15:0] value_q, value_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  hex_q, hex_d;
    logic [3:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic [1:0]  idx_nxt;
    logic        blank;

    refresh_prescaler #(
        .DIV (REFRESH_DIV),
        .W   (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign idx_nxt = idx_q + 2'd1;

    // A digit is a leading zero when it and every digit left of it is zero.
    always_comb begin
        blank = 1'b0;
        unique case (idx_nxt)
            2'd0: blank = 1'b0;
            2'd1: blank = (value_q[15:4] == 12'h000);
            2'd2: blank = (value_q[15:8] == 8'h00);
            2'd3: blank = (value_q[15:12] == 4'h0);
        endcase
        blank = blank & lz_blank_en;
    end

    always_comb begin
        value_d = value_q;
        idx_d   = idx_q;
        hex_d   = hex_q;
        an_d    = an_q;
        dp_d    = dp_q;
        if (load) begin
            value_d = value_in;
        end
        if (tick) begin
            idx_d = idx_nxt;
            hex_d = value_q[{idx_nxt, 2'b00} +: 4];
            if (blank) begin
                an_d = ANODE_OFF;
                dp_d = DP_OFF;
            end else begin
                an_d = anode_sel(idx_nxt);
                dp_d = ~dp_in[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 16'h0000;
            idx_q   <= 2'd3;
            hex_q   <= 4'h0;
            an_q    <= ANODE_OFF;
            dp_q    <= DP_OFF;
        end else begin
            value_q <= value_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign hex_out   = hex_q;
    assign an_out    = an_q;
    assign dp_out    = dp_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner with a 4-cycle refresh slot.
module tb_seg_display_scanner;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  hex_out;
    logic [3:0]  an_out;
    logic        dp_out;
    logic [1:0]  digit_idx;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_hex;
    logic [3:0]  m_an;
    logic        m_dp;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] hex_exp;
        logic [15:0] an_exp;
        logic [3:0]  dpo_exp;
    } vec_t;

    vec_t vecs [6];

    seg_display_scanner #(
        .REFRESH_DIV (DIV),
        .CNT_W       (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .hex_out     (hex_out),
        .an_out      (an_out),
        .dp_out      (dp_out),
        .digit_idx   (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit d shows nibble d of the held value; it is a leading zero when
    // the value shifted right by 4*d is zero (never for digit 0).
    task automatic model_step();
        int d;
        int nib;
        bit blk;
        if (reset) begin
            m_cnt = 0;
            m_idx = 3;
            m_val = 16'h0000;
            m_hex = 4'h0;
            m_an  = 4'hF;
            m_dp  = 1'b1;
        end else begin
            if (m_cnt == DIV - 1) begin
                d   = (m_idx + 1) % 4;
                nib = (int'(m_val) >> (4 * d)) % 16;
                blk = lz_blank_en && d != 0 && ((int'(m_val) >> (4 * d)) == 0);
                m_hex = 4'(nib);
                m_an  = blk ? 4'hF : 4'(15 - (1 << d));
                m_dp  = blk ? 1'b1 : !dp_in[d];
                m_idx = d;
            end
            if (load) begin
                m_val = value_in;
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model_hex", hex_out, m_hex);
        check("model_an", an_out, m_an);
        check("model_dp", dp_out, m_dp);
        check("model_idx", digit_idx, m_idx);
    endtask

    initial begin
        vec_t v;
        int d;

        vecs[0] = '{16'hA3C5, 4'b0000, 1'b0, 16'hA3C5, 16'h7BDE, 4'b1111};
        vecs[1] = '{16'h0007, 4'b0000, 1'b1, 16'h0007, 16'hFFFE, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 16'hFFFE, 4'b1111};
        vecs[3] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 16'h7BDE, 4'b1011};
        vecs[4] = '{16'h0004, 4'b0100, 1'b1, 16'h0004, 16'hFFFE, 4'b1111};
        vecs[5] = '{16'h0000, 4'b1111, 1'b0, 16'h0000, 16'h7BDE, 4'b0000};

        // Reset then idle: dark until the first tick lights digit 0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            check("idle_an", an_out, 4'hF);
            check("idle_dp", dp_out, 1);
            check("idle_idx", digit_idx, 3);
        end
        cyc();
        check("first_tick_an", an_out, 4'hE);
        check("first_tick_hex", hex_out, 0);
        check("first_tick_idx", digit_idx, 0);

        // Table-driven frames, two full frames per vector
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            dp_in = v.dp;
            lz_blank_en = v.lz;
            reset = 1'b1;
            cyc();
            reset = 1'b0;
            load = 1'b1;
            value_in = v.value;
            cyc();
            load = 1'b0;
            value_in = 16'hDEAD;
            for (int c = 2; c <= 8 * DIV; c++) begin
                cyc();
                if (c % DIV == 0) begin
                    d = (c / DIV - 1) % 4;
                    check("vec_hex", hex_out, v.hex_exp[4*d +: 4]);
                    check("vec_an", an_out, v.an_exp[4*d +: 4]);
                    check("vec_dp", dp_out, v.dpo_exp[d]);
                    check("vec_idx", digit_idx, d);
                end
            end
        end

        // Load coinciding with a tick: old value shown, new one next tick
        dp_in = 4'b0000;
        lz_blank_en = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        load = 1'b1;
        value_in = 16'h1111;
        cyc();
        load = 1'b0;
        for (int c = 2; c <= 7; c++) cyc();
        load = 1'b1;
        value_in = 16'hFFFF;
        cyc();
        load = 1'b0;
        check("ldtick_old_hex", hex_out, 4'h1);
        check("ldtick_old_idx", digit_idx, 1);
        for (int c = 9; c <= 12; c++) cyc();
        check("ldtick_new_hex", hex_out, 4'hF);
        check("ldtick_new_an", an_out, 4'hB);

        // Reset mid-frame while digit 2 is lit
        cyc();
        check("mid_pre_an", an_out, 4'hB);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_an", an_out, 4'hF);
        check("mid_rst_hex", hex_out, 0);
        check("mid_rst_idx", digit_idx, 3);
        check("mid_rst_dp", dp_out, 1);
        for (int c = 1; c <= 4; c++) cyc();
        check("mid_after_an", an_out, 4'hE);
        check("mid_after_hex", hex_out, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: value_in = 16'($urandom_range(0, 15));
                1: value_in = 16'($urandom_range(0, 255));
                2: value_in = 16'($urandom_range(0, 4095));
                default: value_in = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz_blank_en = 1'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
